button_enable_control: RTL and testbench
========================================

# button_enable_control

Front-end control stage for the binary counter chain. It conditions a raw, bouncy, active-low push button into the counter's `enable` run/stop level. A short press toggles run/stop. A long press forces stop and emits a one-cycle `long_press` pulse, which the integrating top uses as a clear request. It runs on the FPGA board clock, upstream of the clock divider/counter pair.

## Interface
- `DEBOUNCE_CYCLES`, 200000 — consecutive clk cycles the synchronized button must differ from the debounced level before that level changes (20 ms at 10 MHz); must be ≥1.
- `LONG_PRESS_CYCLES`, 10000000 — debounced-pressed clk cycles that make a press "long" (1 s at 10 MHz); must be ≥1.
- `clk` in 1 — board clock; all state on the rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `button_n` in 1 — raw push button, active-low, asynchronous to clk, may bounce.
- `enable` out 1 — run (1) / stop (0) level for the counter's `enable`; registered.
- `long_press` out 1 — one-cycle pulse on long-press detection; registered.
- `button_level` out 1 — debounced button state, 1 = pressed; registered.

## Operation
- Synchronizer: two flops on `button_n`, inverted to give active-high `btn_sync`. Both flops reset to the released value.
- Debouncer:
  - Counter `db_cnt`, width $clog2(DEBOUNCE_CYCLES+1).
  - If `btn_sync == button_level`, `db_cnt` clears to 0.
  - Otherwise `db_cnt` increments. On the cycle it would reach DEBOUNCE_CYCLES, `button_level` takes `btn_sync` and `db_cnt` clears.
  - A bounce shorter than DEBOUNCE_CYCLES restarts the count and never changes `button_level`.
- FSM, with states IDLE, SHORT and LONG, and a hold counter `hold_cnt` of width $clog2(LONG_PRESS_CYCLES+1):
  - IDLE: on a debounced rising edge of `button_level`, go to SHORT and set `hold_cnt` = 1.
  - SHORT, release (debounced falling edge): `enable` ← ~`enable`, then go to IDLE.
  - SHORT, no release, `hold_cnt == LONG_PRESS_CYCLES`: pulse `long_press` = 1 for one cycle, force `enable` = 0, go to LONG.
  - SHORT otherwise: `hold_cnt` increments, saturating.
  - LONG: on release, go to IDLE with no toggle. `enable` stays 0.
  - Simultaneous release and long threshold in one cycle: release wins. `enable` toggles, no `long_press`.
- Unused state encodings return to IDLE with outputs unchanged.
- Reset (async assert, any time):
  - `enable` = 0, `long_press` = 0, `button_level` = 0.
  - State IDLE, `db_cnt` = 0, `hold_cnt` = 0.
  - Synchronizer flops at released.
- Reset mid-press: after deassertion, a still-held button is debounced as a new press and behaves as a fresh press.

## Timing
- Press latency: `button_n` held steadily low → `button_level` rises DEBOUNCE_CYCLES + 2 rising edges after the first edge that samples low. That is 2 edges for the synchronizer plus DEBOUNCE_CYCLES for the debouncer.
- Release latency: the same, DEBOUNCE_CYCLES + 2 edges after the first edge that samples high.
- Short-press toggle: `enable` changes on the edge following the `button_level` falling edge, i.e. one cycle after.
- Long press: `long_press` is high for exactly one cycle, LONG_PRESS_CYCLES cycles after `button_level` rose. `enable` goes 0 on that same edge.
- `long_press` never asserts twice per press.
- `enable` changes at most once per press.
- Outputs are glitch-free registers. `enable` is static between presses, so the slow divided-clock domain can sample it directly.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES = 4 and LONG_PRESS_CYCLES = 16.
1. Reset: assert `reset` = 0 mid-operation with `enable` = 1 → all outputs 0 immediately, asynchronously. Release reset with button up → outputs stay 0.
2. Clean short press: `button_n` low 10 cycles, then high → `button_level` = 1 at edge 6 after the press. `enable` 0→1 one cycle after `button_level` falls. A second identical press → `enable` 1→0.
3. Bounce rejection: `button_n` toggles with low pulses of 1–3 cycles for 20 cycles, then stays high → `button_level`, `enable` and `long_press` never change.
4. Long press with `enable` = 1: hold `button_n` low 40 cycles → `long_press` = 1 for exactly one cycle, 16 cycles after `button_level` rose, with `enable` → 0 on the same edge. After release → no toggle, `enable` = 0.
5. Threshold race: press so that the debounced release lands exactly on hold count 16 → `enable` toggles, `long_press` stays 0.
6. Reset during hold: assert reset while in SHORT with the button still held, then deassert → `enable` = 0. The button is re-debounced after 6 edges. A later release → `enable` = 1.

Source files
------------

// File: rtl/button_enable_control.sv
// Purpose : turns a raw, bouncy, active-low push button into a run/stop level
//           for the counter chain. A short press toggles run/stop. A long
//           press forces stop and emits a one-cycle clear pulse.
// Latency : button_level follows button_n after DEBOUNCE_CYCLES+2 edges.
//           enable toggles one edge after button_level falls. long_press fires
//           LONG_PRESS_CYCLES edges after button_level rises.
// Backpressure: none. The block is a free-running level conditioner.
//
// Ports:
//   clk          in  board clock; all state changes on the rising edge
//   reset        in  asynchronous reset, active low
//   button_n     in  raw push button, active low, asynchronous, may bounce
//   enable       out registered run (1) / stop (0) level for the counter
//   long_press   out registered one-cycle pulse when a long press is detected
//   button_level out registered debounced button state, 1 = pressed
module button_enable_control #(
  parameter int DEBOUNCE_CYCLES   = 200000,
  parameter int LONG_PRESS_CYCLES = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic enable,
  output logic long_press,
  output logic button_level
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  // The debounced level commits on the cycle the count would reach
  // DEBOUNCE_CYCLES, so the last counted value is DEBOUNCE_CYCLES-1.
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHORT = 2'b01,
    LONG  = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Both flops reset to the released level (high), so a
  // button still held across reset is seen as a brand-new press afterwards.
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic btn_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= button_n;
      sync2_q <= sync1_q;
    end
  end

  assign btn_sync = ~sync2_q;

  // ---------------------------------------------------------------------------
  // Debouncer. Any cycle where the synchronized button agrees with the
  // debounced level restarts the count, so a bounce shorter than
  // DEBOUNCE_CYCLES never moves the level.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            level_q;
  logic            level_d;
  logic            level_prev_q;
  logic            commit;
  logic            rise_evt;
  logic            fall_evt;

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    commit   = 1'b0;
    if (btn_sync != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = btn_sync;
        commit  = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_q     <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  // A press is taken on the same edge the debounced level rises, so the hold
  // count lines up with the cycles button_level has been high. A release is
  // taken from the registered level, which places the enable toggle one edge
  // after button_level falls.
  assign rise_evt = commit & btn_sync;
  assign fall_evt = level_prev_q & ~level_q;

  // ---------------------------------------------------------------------------
  // Press classification FSM: state register.
  // ---------------------------------------------------------------------------
  state_e            state_q;
  state_e            state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              enable_q;
  logic              enable_d;
  logic              long_q;
  logic              long_d;
  logic              at_threshold;

  assign at_threshold = (hold_q == HOLD_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      enable_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      enable_q <= enable_d;
      long_q   <= long_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A release always beats the long-press threshold when
  // both are seen in the same cycle. If a new press commits in the very cycle
  // a release is taken (possible only with a tiny debounce window), go
  // straight back to SHORT so that press is not lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise_evt) state_d = SHORT;
      end
      SHORT: begin
        if (fall_evt)          state_d = rise_evt ? SHORT : IDLE;
        else if (at_threshold) state_d = LONG;
      end
      LONG: begin
        if (fall_evt) state_d = rise_evt ? SHORT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold counter: loads 1 when a press is accepted, then counts up while the
  // press is held in SHORT, saturating at the long-press threshold.
  always_comb begin
    hold_d = hold_q;
    if (rise_evt) begin
      hold_d = HOLD_ONE;
    end else if (state_q == SHORT && !at_threshold) begin
      hold_d = hold_q + HOLD_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic. enable moves only on the release of a short press or the
  // long-press detection, so it changes at most once per press and is steady
  // between presses for the slow counter domain to sample.
  // ---------------------------------------------------------------------------
  always_comb begin
    enable_d = enable_q;
    long_d   = 1'b0;
    case (state_q)
      SHORT: begin
        if (fall_evt) begin
          enable_d = ~enable_q;
        end else if (at_threshold) begin
          long_d   = 1'b1;
          enable_d = 1'b0;
        end
      end
      default: begin
        enable_d = enable_q;
      end
    endcase
  end

  assign enable       = enable_q;
  assign long_press   = long_q;
  assign button_level = level_q;

endmodule

// File: tb/tb_button_enable_control.sv
// Purpose : self-checking bench for button_enable_control with a 4-cycle
//           debounce and a 16-cycle long-press threshold.
// Latency : outputs are sampled 1 time unit after each rising clock edge.
// Backpressure: not applicable.
module tb_button_enable_control;

  localparam int DB = 4;
  localparam int LP = 16;
  // Edge (counted from the first edge that samples the press) on which
  // button_level rises, and on which a long press fires.
  localparam int RISE_EDGE = DB + 2;
  localparam int LONG_EDGE = DB + 2 + LP;

  logic clk;
  logic reset;
  logic button_n;
  logic enable;
  logic long_press;
  logic button_level;

  int vectors;
  int miscompares;

  button_enable_control #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_n    (button_n),
    .enable      (enable),
    .long_press  (long_press),
    .button_level(button_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic btn_n;
    logic exp_level;
    logic exp_tog;
    logic exp_long;
  } vec_t;

  vec_t tbl[20];

  // Compares {button_level, enable, long_press}.
  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: {level,enable,long} got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clean 10-cycle press from the table; base is enable before the press.
  task automatic run_table(input string name, input logic base);
    for (int i = 0; i < 20; i++) begin
      button_n = tbl[i].btn_n;
      tick();
      check(name, {button_level, enable, long_press},
            {tbl[i].exp_level, base ^ tbl[i].exp_tog, tbl[i].exp_long});
    end
  endtask

  // Clean press: button_n low for edges 1..low_edges, checked each edge.
  task automatic press(input string name, input int low_edges, input int n_edges, input logic e0);
    int   long_e;
    int   tog_e;
    logic el;
    logic ee;
    logic elp;
    long_e = (low_edges >= LP) ? LONG_EDGE : 0;
    tog_e  = (low_edges <= LP - 1) ? low_edges + DB + 3 : 0;
    button_n = 1'b0;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == low_edges + 1) button_n = 1'b1;
      tick();
      el  = (k >= RISE_EDGE) && (k <= low_edges + DB + 1);
      ee  = e0;
      if (tog_e != 0 && k >= tog_e)       ee = ~e0;
      else if (long_e != 0 && k >= long_e) ee = 1'b0;
      elp = (k == long_e);
      check(name, {button_level, enable, long_press}, {el, ee, elp});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:19] bounce;
    vectors     = 0;
    miscompares = 0;

    // Row i is applied before edge i+1 and checked after it.
    for (int i = 0; i < 20; i++) begin
      tbl[i].btn_n     = (i < 10) ? 1'b0 : 1'b1;
      tbl[i].exp_level = (i >= 5 && i <= 14);
      tbl[i].exp_tog   = (i >= 16);
      tbl[i].exp_long  = 1'b0;
    end

    // Reset state.
    reset    = 1'b0;
    button_n = 1'b1;
    #1;
    check("reset_state", {button_level, enable, long_press}, 3'b000);
    repeat (3) begin
      tick();
      check("reset_held", {button_level, enable, long_press}, 3'b000);
    end
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("post_reset_idle", {button_level, enable, long_press}, 3'b000);
    end

    // Short presses: 0->1, 1->0, then 0->1 again.
    run_table("short_press_a", 1'b0);
    run_table("short_press_b", 1'b1);
    run_table("short_press_c", 1'b0);

    // Long press with enable=1: pulse on edge 22, enable forced 0, no toggle on release.
    press("long_press", 40, 50, 1'b1);

    // Bounce rejection: low pulses of 1..3 cycles, then steady high.
    bounce = 20'b01001000110100010111;
    for (int i = 0; i < 30; i++) begin
      button_n = (i < 20) ? bounce[i] : 1'b1;
      tick();
      check("bounce", {button_level, enable, long_press}, 3'b000);
    end

    // Release seen one cycle after the threshold: long press wins, no toggle.
    press("threshold_long", LP, 26, 1'b0);
    // Release seen in the same cycle as the threshold: release wins, toggle.
    press("threshold_race", LP - 1, 26, 1'b0);

    // Asynchronous reset with enable=1.
    repeat (2) begin
      tick();
      check("pre_async_reset", {button_level, enable, long_press}, 3'b010);
    end
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {button_level, enable, long_press}, 3'b000);
    tick();
    check("async_reset_held", {button_level, enable, long_press}, 3'b000);
    reset = 1'b1;
    repeat (6) begin
      tick();
      check("async_reset_release", {button_level, enable, long_press}, 3'b000);
    end

    // Reset while in SHORT with the button still held.
    button_n = 1'b0;
    repeat (10) tick();
    check("hold_before_reset", {button_level, enable, long_press}, 3'b100);
    #2;
    reset = 1'b0;
    #1;
    check("reset_during_hold", {button_level, enable, long_press}, 3'b000);
    tick();
    check("reset_during_hold_held", {button_level, enable, long_press}, 3'b000);
    reset = 1'b1;
    press("repress_after_reset", 8, 18, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
